// File: rtl/noc_params.sv
// Router-wide NoC dimensions and the index types and wrap helpers shared by the router blocks.
package noc_params;

    localparam int unsigned PORT_NUM = 5;
    localparam int unsigned VC_NUM   = 2;
    localparam int unsigned PORT_W   = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
    localparam int unsigned VC_W     = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    typedef logic [PORT_W-1:0] port_t;
    typedef logic [VC_W-1:0]   vc_t;

    function automatic vc_t vc_next(vc_t v);
        if (32'(v) == VC_NUM - 1) return '0;
        return v + vc_t'(1);
    endfunction

    function automatic port_t port_next(port_t p);
        if (32'(p) == PORT_NUM - 1) return '0;
        return p + port_t'(1);
    endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant and credit-return bundle between the input ports and the switch allocator.
interface switch_allocator_if;
    import noc_params::*;

    logic  [PORT_NUM-1:0][VC_NUM-1:0] valid_i;
    port_t [PORT_NUM-1:0][VC_NUM-1:0] out_port_i;
    vc_t   [PORT_NUM-1:0][VC_NUM-1:0] ds_vc_i;
    logic  [PORT_NUM-1:0]             credit_valid_i;
    vc_t   [PORT_NUM-1:0]             credit_vc_i;

    logic  [PORT_NUM-1:0][VC_NUM-1:0] read_o;
    vc_t   [PORT_NUM-1:0]             vc_sel_o;
    port_t [PORT_NUM-1:0]             in_sel_o;
    logic  [PORT_NUM-1:0]             out_valid_o;

    modport master (
        output valid_i, out_port_i, ds_vc_i, credit_valid_i, credit_vc_i,
        input  read_o, vc_sel_o, in_sel_o, out_valid_o
    );

    modport slave (
        input  valid_i, out_port_i, ds_vc_i, credit_valid_i, credit_vc_i,
        output read_o, vc_sel_o, in_sel_o, out_valid_o
    );

endinterface

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr_i wins, wrapping at N.
module round_robin_arbiter #(
    parameter int unsigned N = 2,
    parameter int unsigned W = 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    always_comb begin
        int unsigned j;
        logic        found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr_i) + k) % N;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = W'(j);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator with per-(output, downstream VC) credit tracking.
module switch_allocator
    import noc_params::*;
#(
    parameter int unsigned BUFFER_SIZE = 8
) (
    input logic               clk,
    input logic               rst,
    switch_allocator_if.slave sa
);

    localparam int unsigned CW = $clog2(BUFFER_SIZE + 1);
    typedef logic [CW-1:0] credit_t;

    credit_t [PORT_NUM-1:0][VC_NUM-1:0] credit_q, credit_d;
    vc_t     [PORT_NUM-1:0]             in_ptr_q, in_ptr_d;
    port_t   [PORT_NUM-1:0]             out_ptr_q, out_ptr_d;

    logic    [PORT_NUM-1:0][VC_NUM-1:0] elig, s1_gnt;
    vc_t     [PORT_NUM-1:0]             s1_idx;
    logic    [PORT_NUM-1:0]             s1_any;
    port_t   [PORT_NUM-1:0]             s1_port;
    // Indexed [output][input].
    logic    [PORT_NUM-1:0][PORT_NUM-1:0] out_req, s2_gnt;
    port_t   [PORT_NUM-1:0]             s2_idx;
    logic    [PORT_NUM-1:0]             s2_any;
    logic    [PORT_NUM-1:0]             in_won;
    vc_t     [PORT_NUM-1:0]             grant_ds;

    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < PORT_NUM; i++) begin
            for (int unsigned v = 0; v < VC_NUM; v++) begin
                port_t op;
                vc_t   dv;
                op = sa.out_port_i[i][v];
                dv = sa.ds_vc_i[i][v];
                if (sa.valid_i[i][v] && (32'(op) < PORT_NUM)) begin
                    elig[i][v] = (credit_q[op][dv] != '0);
                end
            end
        end
    end

    for (genvar i = 0; i < PORT_NUM; i++) begin : g_stage1
        round_robin_arbiter #(
            .N (VC_NUM),
            .W (VC_W)
        ) u_arb (
            .req_i (elig[i]),
            .ptr_i (in_ptr_q[i]),
            .gnt_o (s1_gnt[i]),
            .idx_o (s1_idx[i]),
            .any_o (s1_any[i])
        );
    end

    always_comb begin
        s1_port = '0;
        out_req = '0;
        for (int unsigned i = 0; i < PORT_NUM; i++) begin
            s1_port[i] = sa.out_port_i[i][s1_idx[i]];
        end
        for (int unsigned p = 0; p < PORT_NUM; p++) begin
            for (int unsigned i = 0; i < PORT_NUM; i++) begin
                out_req[p][i] = s1_any[i] && (s1_port[i] == port_t'(p));
            end
        end
    end

    for (genvar p = 0; p < PORT_NUM; p++) begin : g_stage2
        round_robin_arbiter #(
            .N (PORT_NUM),
            .W (PORT_W)
        ) u_arb (
            .req_i (out_req[p]),
            .ptr_i (out_ptr_q[p]),
            .gnt_o (s2_gnt[p]),
            .idx_o (s2_idx[p]),
            .any_o (s2_any[p])
        );
    end

    // An input that loses stage 2 keeps its VC pointer so its winner retries first.
    always_comb begin
        in_won    = '0;
        grant_ds  = '0;
        in_ptr_d  = in_ptr_q;
        out_ptr_d = out_ptr_q;
        for (int unsigned p = 0; p < PORT_NUM; p++) begin
            if (s2_any[p]) begin
                in_won[s2_idx[p]]   = 1'b1;
                grant_ds[p]         = sa.ds_vc_i[s2_idx[p]][s1_idx[s2_idx[p]]];
                out_ptr_d[p]        = port_next(s2_idx[p]);
                in_ptr_d[s2_idx[p]] = vc_next(s1_idx[s2_idx[p]]);
            end
        end
    end

    always_comb begin
        sa.read_o      = '0;
        sa.vc_sel_o    = '0;
        sa.in_sel_o    = '0;
        sa.out_valid_o = '0;
        if (rst) begin
            for (int unsigned i = 0; i < PORT_NUM; i++) begin
                if (in_won[i]) begin
                    sa.read_o[i]   = s1_gnt[i];
                    sa.vc_sel_o[i] = s1_idx[i];
                end
            end
            for (int unsigned p = 0; p < PORT_NUM; p++) begin
                if (s2_any[p]) begin
                    sa.in_sel_o[p]    = s2_idx[p];
                    sa.out_valid_o[p] = 1'b1;
                end
            end
        end
    end

    // A grant and a returned credit on the same counter cancel out.
    always_comb begin
        credit_d = credit_q;
        for (int unsigned p = 0; p < PORT_NUM; p++) begin
            for (int unsigned d = 0; d < VC_NUM; d++) begin
                logic dec;
                logic inc;
                dec = s2_any[p] && (grant_ds[p] == vc_t'(d));
                inc = sa.credit_valid_i[p] && (sa.credit_vc_i[p] == vc_t'(d));
                if (dec && !inc) begin
                    credit_d[p][d] = credit_q[p][d] - credit_t'(1);
                end else if (inc && !dec && (credit_q[p][d] != credit_t'(BUFFER_SIZE))) begin
                    credit_d[p][d] = credit_q[p][d] + credit_t'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned p = 0; p < PORT_NUM; p++) begin
                for (int unsigned d = 0; d < VC_NUM; d++) begin
                    credit_q[p][d] <= credit_t'(BUFFER_SIZE);
                end
            end
            in_ptr_q  <= '0;
            out_ptr_q <= '0;
        end else begin
            credit_q  <= credit_d;
            in_ptr_q  <= in_ptr_d;
            out_ptr_q <= out_ptr_d;
        end
    end

    for (genvar p = 0; p < PORT_NUM; p++) begin : g_credit_chk
        always_ff @(posedge clk) begin
            if (rst && sa.credit_valid_i[p] &&
                !(s2_any[p] && (grant_ds[p] == sa.credit_vc_i[p]))) begin
                assert (credit_q[p][sa.credit_vc_i[p]] != credit_t'(BUFFER_SIZE))
                else $warning("credit overflow on output %0d vc %0d", p, sa.credit_vc_i[p]);
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Randomized and directed bench for switch_allocator against a behavioural allocation model.
module tb_switch_allocator;
    import noc_params::*;

    localparam int BSIZE = 8;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    switch_allocator_if sa_if ();

    switch_allocator #(
        .BUFFER_SIZE (BSIZE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sa  (sa_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state.
    int m_credit [PORT_NUM][VC_NUM];
    int m_in_ptr [PORT_NUM];
    int m_out_ptr[PORT_NUM];
    int m_win_v  [PORT_NUM];
    int m_win_i  [PORT_NUM];

    logic  [PORT_NUM-1:0][VC_NUM-1:0] e_read;
    vc_t   [PORT_NUM-1:0]             e_vcsel;
    port_t [PORT_NUM-1:0]             e_insel;
    logic  [PORT_NUM-1:0]             e_ov;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        sa_if.valid_i        = '0;
        sa_if.out_port_i     = '0;
        sa_if.ds_vc_i        = '0;
        sa_if.credit_valid_i = '0;
        sa_if.credit_vc_i    = '0;
    endtask

    task automatic model_reset();
        for (int p = 0; p < int'(PORT_NUM); p++) begin
            for (int d = 0; d < int'(VC_NUM); d++) m_credit[p][d] = BSIZE;
            m_in_ptr[p]  = 0;
            m_out_ptr[p] = 0;
        end
    endtask

    task automatic model_eval();
        e_read = '0; e_vcsel = '0; e_insel = '0; e_ov = '0;
        for (int i = 0; i < int'(PORT_NUM); i++) begin
            m_win_v[i] = -1;
            for (int k = 0; k < int'(VC_NUM); k++) begin
                int v, op, d;
                v  = (m_in_ptr[i] + k) % int'(VC_NUM);
                op = int'(sa_if.out_port_i[i][v]);
                d  = int'(sa_if.ds_vc_i[i][v]);
                if (m_win_v[i] < 0 && sa_if.valid_i[i][v] && m_credit[op][d] > 0) m_win_v[i] = v;
            end
        end
        for (int p = 0; p < int'(PORT_NUM); p++) begin
            m_win_i[p] = -1;
            for (int k = 0; k < int'(PORT_NUM); k++) begin
                int i;
                i = (m_out_ptr[p] + k) % int'(PORT_NUM);
                if (m_win_i[p] < 0 && m_win_v[i] >= 0 &&
                    int'(sa_if.out_port_i[i][m_win_v[i]]) == p) m_win_i[p] = i;
            end
            if (m_win_i[p] >= 0) begin
                e_read[m_win_i[p]][m_win_v[m_win_i[p]]] = 1'b1;
                e_vcsel[m_win_i[p]] = vc_t'(m_win_v[m_win_i[p]]);
                e_insel[p] = port_t'(m_win_i[p]);
                e_ov[p]    = 1'b1;
            end
        end
    endtask

    task automatic model_update();
        int dec[PORT_NUM][VC_NUM];
        for (int p = 0; p < int'(PORT_NUM); p++)
            for (int d = 0; d < int'(VC_NUM); d++) dec[p][d] = 0;
        for (int p = 0; p < int'(PORT_NUM); p++) begin
            if (m_win_i[p] >= 0) begin
                int i, v;
                i = m_win_i[p];
                v = m_win_v[i];
                dec[p][int'(sa_if.ds_vc_i[i][v])] = 1;
                m_in_ptr[i]  = (v + 1) % int'(VC_NUM);
                m_out_ptr[p] = (i + 1) % int'(PORT_NUM);
            end
        end
        for (int p = 0; p < int'(PORT_NUM); p++) begin
            for (int d = 0; d < int'(VC_NUM); d++) begin
                int inc;
                inc = (sa_if.credit_valid_i[p] && int'(sa_if.credit_vc_i[p]) == d) ? 1 : 0;
                if (dec[p][d] == 1 && inc == 0) m_credit[p][d] -= 1;
                else if (inc == 1 && dec[p][d] == 0 && m_credit[p][d] < BSIZE) m_credit[p][d] += 1;
            end
        end
    endtask

    task automatic eval_cycle();
        @(negedge clk);
        model_eval();
        check("read",      32'(sa_if.read_o),      32'(e_read));
        check("vc_sel",    32'(sa_if.vc_sel_o),    32'(e_vcsel));
        check("in_sel",    32'(sa_if.in_sel_o),    32'(e_insel));
        check("out_valid", 32'(sa_if.out_valid_o), 32'(e_ov));
    endtask

    task automatic end_cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        for (int p = 0; p < int'(PORT_NUM); p++) begin
            for (int d = 0; d < int'(VC_NUM); d++)
                check({tag, "_credit"}, 32'(dut.credit_q[p][d]), 32'(BSIZE));
        end
        check({tag, "_in_ptr"},  32'(dut.in_ptr_q),  32'(0));
        check({tag, "_out_ptr"}, 32'(dut.out_ptr_q), 32'(0));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_read"},  32'(sa_if.read_o),      32'(0));
        check({tag, "_vcsel"}, 32'(sa_if.vc_sel_o),    32'(0));
        check({tag, "_insel"}, 32'(sa_if.in_sel_o),    32'(0));
        check({tag, "_ov"},    32'(sa_if.out_valid_o), 32'(0));
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst     = 1'b0;
        clear_inputs();
        model_reset();

        // Outputs must stay low in reset even with every VC requesting.
        sa_if.valid_i = '1;
        for (int i = 0; i < int'(PORT_NUM); i++)
            for (int v = 0; v < int'(VC_NUM); v++)
                sa_if.out_port_i[i][v] = port_t'($urandom_range(0, PORT_NUM - 1));
        repeat (2) @(posedge clk);
        #2;
        check_outputs_zero("rst_hold");
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_state("post_rst");

        // Two inputs contending for output 2 alternate.
        do_reset();
        sa_if.valid_i[0][0] = 1'b1; sa_if.out_port_i[0][0] = 3'd2;
        sa_if.valid_i[1][0] = 1'b1; sa_if.out_port_i[1][0] = 3'd2;
        for (int k = 0; k < 6; k++) begin
            eval_cycle();
            check("alt_in_sel2", 32'(sa_if.in_sel_o[2]), 32'(k % 2));
            check("alt_ov2", 32'(sa_if.out_valid_o[2]), 32'(1));
            end_cycle();
        end

        // One input with two VCs alternates between them, one read at a time.
        do_reset();
        sa_if.valid_i[3] = 2'b11;
        sa_if.out_port_i[3][0] = 3'd1;
        sa_if.out_port_i[3][1] = 3'd4;
        for (int k = 0; k < 6; k++) begin
            eval_cycle();
            check("vc_alt_sel3", 32'(sa_if.vc_sel_o[3]), 32'(k % 2));
            check("vc_alt_onehot", 32'($countones(sa_if.read_o)), 32'(1));
            end_cycle();
        end

        // Credit exhaustion then a single returned credit.
        do_reset();
        sa_if.valid_i[0][0] = 1'b1; sa_if.out_port_i[0][0] = 3'd1;
        for (int k = 0; k < 10; k++) begin
            eval_cycle();
            check("drain_ov1", 32'(sa_if.out_valid_o[1]), 32'(k < BSIZE));
            end_cycle();
        end
        sa_if.credit_valid_i[1] = 1'b1;
        sa_if.credit_vc_i[1] = '0;
        eval_cycle();
        check("credit_same_cycle", 32'(sa_if.out_valid_o[1]), 32'(0));
        end_cycle();
        sa_if.credit_valid_i[1] = 1'b0;
        eval_cycle();
        check("credit_next_cycle", 32'(sa_if.out_valid_o[1]), 32'(1));
        end_cycle();
        eval_cycle();
        check("credit_used_up", 32'(sa_if.out_valid_o[1]), 32'(0));
        end_cycle();

        // Grant and credit together hold the count; saturation at the top.
        do_reset();
        sa_if.valid_i[0][0] = 1'b1; sa_if.out_port_i[0][0] = 3'd1;
        repeat (3) begin eval_cycle(); end_cycle(); end
        check("cnt_at5", 32'(dut.credit_q[1][0]), 32'(5));
        sa_if.credit_valid_i[1] = 1'b1;
        sa_if.credit_vc_i[1] = '0;
        eval_cycle();
        end_cycle();
        check("grant_and_credit", 32'(dut.credit_q[1][0]), 32'(5));
        sa_if.valid_i = '0;
        repeat (3) begin eval_cycle(); end_cycle(); end
        check("refilled", 32'(dut.credit_q[1][0]), 32'(BSIZE));
        eval_cycle();
        end_cycle();
        check("saturate", 32'(dut.credit_q[1][0]), 32'(BSIZE));
        sa_if.credit_valid_i = '0;

        // Asynchronous reset mid-stream.
        do_reset();
        sa_if.valid_i[0][0] = 1'b1; sa_if.out_port_i[0][0] = 3'd1;
        repeat (5) begin eval_cycle(); end_cycle(); end
        check("mid_cnt3", 32'(dut.credit_q[1][0]), 32'(3));
        #2;
        check("mid_pre_ov", 32'(sa_if.out_valid_o[1]), 32'(1));
        rst = 1'b0;
        #1;
        check_outputs_zero("mid_rst");
        check_reset_state("mid_rst");
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;
        #1;
        check_reset_state("mid_release");
        eval_cycle();
        end_cycle();

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < int'(PORT_NUM); i++) begin
                for (int v = 0; v < int'(VC_NUM); v++) begin
                    sa_if.valid_i[i][v]    = ($urandom_range(0, 99) < 60);
                    sa_if.out_port_i[i][v] = port_t'($urandom_range(0, PORT_NUM - 1));
                    sa_if.ds_vc_i[i][v]    = vc_t'($urandom_range(0, VC_NUM - 1));
                end
            end
            for (int p = 0; p < int'(PORT_NUM); p++) begin
                int d;
                d = int'($urandom_range(0, VC_NUM - 1));
                sa_if.credit_vc_i[p]    = vc_t'(d);
                sa_if.credit_valid_i[p] = ($urandom_range(0, 1) == 1) && (m_credit[p][d] < BSIZE);
            end
            eval_cycle();
            end_cycle();
        end
        clear_inputs();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
